axis_pkt_fifo: RTL

Parametrised AXI-Stream FIFO with per-beat `tlast` storage, fill-level reporting, almost-full/almost-empty flags and an optional store-and-forward packet mode. It replaces single-width ping-pong FIFOs in the streaming datapath. It sits between any two AXI-Stream stages, typically ahead of packet-oriented consumers that must not see partial frames.

---
 rtl/axis_fifo_pkg.sv | 25 ++
 rtl/axis_fifo_ram.sv | 28 ++
 rtl/axis_pkt_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-Stream packet FIFO: width calculations and mode constants.
package axis_fifo_pkg;

    localparam int unsigned MODE_CUT = 0;
    localparam int unsigned MODE_PKT = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pointer carries one extra wrap bit to tell full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage with registered read port; array is deliberately not reset.
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 2048
) (
    input  logic                    clk,
    input  logic                    wr_en_i,
    input  logic [clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    rd_en_i,
    input  logic [clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]        rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with tlast storage, level/threshold flags and optional store-and-forward mode.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned PACKET_MODE = MODE_CUT,
    parameter int unsigned AF_THRESH   = DEPTH - 4,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      cut_pulse
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);
    localparam bit PKT = (PACKET_MODE == MODE_PKT);

    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [LW-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic [LW-1:0]         pend_q, pend_d;
    logic                  rel_q, rel_d;
    logic                  cut_q, cut_d;
    logic                  s_rdy_q, af_q, ae_q;
    logic                  stage_vld_q, stage_vld_d;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_vld_q, m_last_q;
    logic [DATA_WIDTH:0]   ram_rdata;
    logic                  wr_fire, rd_fire, ram_empty, stage_last;
    logic                  rd_ok, load_ok, ram_rd, out_load;

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({s_tlast, s_tdata}),
        .rd_en_i   (ram_rd),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (ram_rdata)
    );

    // pend_q counts tlast beats still in RAM or the read stage; it gates prefetch so
    // a partial frame never enters the read stage or output register.
    always_comb begin
        wr_fire    = s_tvalid && s_rdy_q;
        rd_fire    = m_vld_q && m_tready;
        ram_empty  = (wr_ptr_q == rd_ptr_q);
        stage_last = stage_vld_q && ram_rdata[DATA_WIDTH];
        rd_ok      = 1'b1;
        load_ok    = 1'b1;
        if (PKT) begin
            load_ok = rel_q || (pend_q != '0);
            rd_ok   = rel_q || (pend_q > LW'(stage_last));
        end
        out_load    = stage_vld_q && load_ok && (!m_vld_q || m_tready);
        ram_rd      = !ram_empty && rd_ok && (!stage_vld_q || out_load);
        stage_vld_d = ram_rd || (stage_vld_q && !out_load);

        level_d   = level_q + LW'(wr_fire) - LW'(rd_fire);
        pkt_cnt_d = pkt_cnt_q + LW'(wr_fire && s_tlast) - LW'(rd_fire && m_last_q);
        pend_d    = pend_q + LW'(wr_fire && s_tlast) - LW'(out_load && stage_last);

        cut_d = PKT && !rel_q && (level_q == FULL_L) && (pkt_cnt_q == '0);
        rel_d = rel_q;
        if (cut_d) begin
            rel_d = 1'b1;
        end else if (rel_q && rd_fire && m_last_q) begin
            rel_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_cnt_q   <= '0;
            pend_q      <= '0;
            rel_q       <= 1'b0;
            cut_q       <= 1'b0;
            s_rdy_q     <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            stage_vld_q <= 1'b0;
            m_data_q    <= '0;
            m_vld_q     <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + PW'(wr_fire);
            rd_ptr_q    <= rd_ptr_q + PW'(ram_rd);
            level_q     <= level_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pend_q      <= pend_d;
            rel_q       <= rel_d;
            cut_q       <= cut_d;
            s_rdy_q     <= (level_d < FULL_L);
            af_q        <= (level_d >= AF_L);
            ae_q        <= (level_d <= AE_L);
            stage_vld_q <= stage_vld_d;
            if (out_load) begin
                m_vld_q  <= 1'b1;
                m_data_q <= ram_rdata[DATA_WIDTH-1:0];
                m_last_q <= ram_rdata[DATA_WIDTH];
            end else if (rd_fire) begin
                m_vld_q <= 1'b0;
            end
        end
    end

    assign s_tready     = s_rdy_q;
    assign m_tdata      = m_data_q;
    assign m_tvalid     = m_vld_q;
    assign m_tlast      = m_last_q;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign cut_pulse    = cut_q;

endmodule
